// File: rtl/buffer_reader_pkg.sv
// Shared definitions for the receive-buffer read path: ASCII constants,
// default buffer geometry and the reader FSM state encoding.
package buffer_reader_pkg;

    // Default address width of the UART receive buffer (2 KiB of characters).
    localparam int BUF_ADDR_W = 11;

    // Width of the stored characters (7-bit ASCII).
    localparam int ASCII_W = 7;

    // First printable ASCII code; anything below is a control character.
    localparam logic [ASCII_W-1:0] ASCII_SPACE = 7'h20;

    // Reader FSM state encoding, kept here so other blocks and benches can
    // decode the state without duplicating the values.
    localparam int RD_STATE_W = 2;

    typedef enum logic [RD_STATE_W-1:0] {
        ST_IDLE    = 2'd0,  // waiting for unread data
        ST_SETTLE  = 2'd1,  // waiting out the buffer read latency
        ST_PRESENT = 2'd2,  // character offered downstream
        ST_ADVANCE = 2'd3   // step read pointer past the consumed slot
    } rd_state_e;

endpackage : buffer_reader_pkg

// File: rtl/buffer_reader_if.sv
// Character stream between the buffer reader and its consumer.
// The master drives data/valid and holds them until ready is seen.
interface buffer_reader_if #(
    parameter int DATA_W = 7
);
    logic [DATA_W-1:0] char_data;
    logic              char_valid;
    logic              char_ready;

    // Producer side (buffer reader).
    modport master (
        output char_data,
        output char_valid,
        input  char_ready
    );

    // Consumer side (e.g. Morse encoder).
    modport slave (
        input  char_data,
        input  char_valid,
        output char_ready
    );

endinterface : buffer_reader_if

// File: rtl/buffer_reader.sv
// Read side of the UART receive buffer. Walks read_index from the oldest
// unread slot towards write_index, waits for the buffer read data to settle,
// and offers each character on a valid/ready stream. Control characters can
// optionally be dropped without being offered.
module buffer_reader
    import buffer_reader_pkg::*;
#(
    parameter int ADDR_W        = BUF_ADDR_W,
    parameter int DATA_W        = ASCII_W,
    parameter int SETTLE_CYCLES = 3,
    parameter int STRIP_CTRL    = 1
) (
    input  logic              clk_24,
    input  logic              rst,
    input  logic [ADDR_W-1:0] write_index,
    input  logic              rx,
    input  logic [DATA_W-1:0] ascii_in,
    input  logic              flush,
    output logic [ADDR_W-1:0] read_index,
    output logic [ADDR_W-1:0] pending,
    output logic              empty,
    buffer_reader_if.master   char_if
);

    // Counter wide enough to reach SETTLE_CYCLES-1 without overflowing
    // before the sample point.
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    // True for characters that are never offered downstream when stripping.
    function automatic logic is_ctrl(input logic [DATA_W-1:0] ch);
        return ch < DATA_W'(ASCII_SPACE);
    endfunction

    rd_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] read_index_q, read_index_d;
    logic [DATA_W-1:0] char_data_q, char_data_d;
    logic              char_valid_q, char_valid_d;

    logic [ADDR_W-1:0] pending_w;
    logic              empty_w;

    // Unread count; modular subtraction makes a wrapped equal pointer read as empty.
    always_comb begin
        pending_w = write_index - read_index_q;
        empty_w   = (pending_w == '0);
    end

    // Next-state logic: flush overrides the walk, otherwise step the read FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        read_index_d = read_index_q;
        char_data_d  = char_data_q;
        char_valid_d = char_valid_q;

        if (flush) begin
            // Drop everything unread, including a character on offer this edge.
            read_index_d = write_index;
            char_valid_d = 1'b0;
            state_d      = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!empty_w) begin
                        cnt_d   = '0;
                        state_d = ST_SETTLE;
                    end
                end

                ST_SETTLE: begin
                    if (rx) begin
                        // The buffer ignores read_index while it is being written,
                        // so the read latency has to be waited out from scratch.
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_LAST) begin
                            char_data_d = ascii_in;
                            if ((STRIP_CTRL != 0) && is_ctrl(ascii_in)) begin
                                state_d = ST_ADVANCE;
                            end else begin
                                char_valid_d = 1'b1;
                                state_d      = ST_PRESENT;
                            end
                        end
                    end
                end

                ST_PRESENT: begin
                    if (char_if.char_ready) begin
                        char_valid_d = 1'b0;
                        state_d      = ST_ADVANCE;
                    end
                end

                ST_ADVANCE: begin
                    // Natural ADDR_W-bit wrap matches the circular buffer.
                    read_index_d = read_index_q + ADDR_W'(1);
                    state_d      = ST_IDLE;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State registers; reset wins over flush and any handshake in progress.
    always_ff @(posedge clk_24) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            read_index_q <= '0;
            char_data_q  <= '0;
            char_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            read_index_q <= read_index_d;
            char_data_q  <= char_data_d;
            char_valid_q <= char_valid_d;
        end
    end

    assign read_index         = read_index_q;
    assign pending            = pending_w;
    assign empty              = empty_w;
    assign char_if.char_data  = char_data_q;
    assign char_if.char_valid = char_valid_q;

endmodule : buffer_reader

// File: tb/tb_buffer_reader.sv
// Bench for buffer_reader: a behavioural receive buffer (memory plus a
// two-cycle read pipeline that returns garbage while being written) feeds the
// DUT, and a queue of written characters predicts the delivered stream.
module tb_buffer_reader;
    import buffer_reader_pkg::*;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 7;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk_24 = 1'b0;
    logic              rst;
    logic              rx;
    logic              flush;
    logic [ADDR_W-1:0] write_index;
    logic [ADDR_W-1:0] read_index;
    logic [ADDR_W-1:0] pending;
    logic              empty;
    logic [DATA_W-1:0] ascii_in;
    logic [DATA_W-1:0] wdata;

    buffer_reader_if #(.DATA_W(DATA_W)) char_if ();

    buffer_reader #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .SETTLE_CYCLES(3),
        .STRIP_CTRL(1)
    ) dut (
        .clk_24     (clk_24),
        .rst        (rst),
        .write_index(write_index),
        .rx         (rx),
        .ascii_in   (ascii_in),
        .flush      (flush),
        .read_index (read_index),
        .pending    (pending),
        .empty      (empty),
        .char_if    (char_if)
    );

    always #21 clk_24 = ~clk_24;

    // Behavioural buffer memory with two cycles of read latency.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_s1, rd_s2;

    always @(posedge clk_24) begin
        rd_s1 <= rx ? DATA_W'($urandom) : mem[read_index];
        rd_s2 <= rd_s1;
    end
    assign ascii_in = rd_s2;

    int n_checks = 0;
    int n_fail   = 0;
    int xfer_cnt = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference stream: characters in write order, flushed on flush/reset,
    // control characters skipped when a transfer is seen.
    logic [DATA_W-1:0] exp_q [$];
    bit                hold_prev = 1'b0;
    logic [DATA_W-1:0] data_prev;

    always @(negedge clk_24) begin
        if (hold_prev) begin
            check("hold_valid", 32'(char_if.char_valid), 32'd1);
            check("hold_data", 32'(char_if.char_data), 32'(data_prev));
        end
        if (rst) begin
            exp_q.delete();
        end else if (flush) begin
            exp_q.delete();
        end else if (char_if.char_valid && char_if.char_ready) begin
            while (exp_q.size() > 0 && exp_q[0] < ASCII_SPACE)
                void'(exp_q.pop_front());
            if (exp_q.size() == 0)
                check("xfer_unexpected", 32'd1, 32'd0);
            else
                check("xfer_data", 32'(char_if.char_data), 32'(exp_q.pop_front()));
            xfer_cnt <= xfer_cnt + 1;
        end
        if (rx && !rst)
            exp_q.push_back(wdata);
        hold_prev <= char_if.char_valid && !char_if.char_ready && !flush && !rst;
        data_prev <= char_if.char_data;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_24);
        #1;
    endtask

    task automatic push_char(input logic [DATA_W-1:0] ch);
        rx    = 1'b1;
        wdata = ch;
        @(posedge clk_24);
        #1;
        mem[write_index] = ch;
        write_index      = write_index + ADDR_W'(1);
        rx               = 1'b0;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        rx          = 1'b0;
        flush       = 1'b0;
        write_index = '0;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic flush_to(input logic [ADDR_W-1:0] idx);
        write_index = idx;
        flush       = 1'b1;
        tick(1);
        flush = 1'b0;
    endtask

    task automatic wait_valid(input int budget, input string tag);
        int k = 0;
        while (!char_if.char_valid && k < budget) begin
            tick(1);
            k++;
        end
        check({tag, "_seen"}, 32'(char_if.char_valid), 32'd1);
    endtask

    task automatic drain(input int budget, input string tag);
        int k = 0;
        char_if.char_ready = 1'b1;
        while (!(empty && !char_if.char_valid) && k < budget) begin
            tick(1);
            k++;
        end
        check({tag, "_drained"}, 32'(empty && !char_if.char_valid), 32'd1);
    endtask

    initial begin
        #(42 * 60000);
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int left;
        int r;
        logic [DATA_W-1:0] ch;

        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        wdata = '0;

        // Reset while other inputs carry garbage.
        rst                = 1'b1;
        rx                 = 1'b0;
        flush              = 1'b1;
        char_if.char_ready = 1'b1;
        write_index        = ADDR_W'($urandom);
        tick(2);
        do_reset();
        check("rst_read_index", 32'(read_index), 32'd0);
        check("rst_valid", 32'(char_if.char_valid), 32'd0);
        check("rst_data", 32'(char_if.char_data), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_pending", 32'(pending), 32'd0);

        // Single character: valid on the 4th edge after data becomes visible.
        char_if.char_ready = 1'b1;
        push_char(7'h41);
        tick(3);
        check("single_early", 32'(char_if.char_valid), 32'd0);
        tick(1);
        check("single_valid", 32'(char_if.char_valid), 32'd1);
        check("single_data", 32'(char_if.char_data), 32'h41);
        tick(2);
        check("single_ptr", 32'(read_index), 32'd1);
        check("single_empty", 32'(empty), 32'd1);
        check("single_xfers", 32'(xfer_cnt), 32'd1);

        // Backpressure: 'S','O','S' queued behind a stalled consumer.
        base = xfer_cnt;
        char_if.char_ready = 1'b0;
        push_char(7'h53);
        push_char(7'h4F);
        push_char(7'h53);
        tick(20);
        check("bp_valid", 32'(char_if.char_valid), 32'd1);
        check("bp_data", 32'(char_if.char_data), 32'h53);
        check("bp_pending", 32'(pending), 32'd3);
        drain(100, "bp");
        check("bp_xfers", 32'(xfer_cnt - base), 32'd3);
        check("bp_ptr", 32'(read_index), 32'd4);

        // Write strobe in the middle of the settle wait restarts it.
        base = xfer_cnt;
        char_if.char_ready = 1'b1;
        push_char(7'h58);
        tick(2);
        push_char(7'h59);
        tick(1);
        check("stall_e4", 32'(char_if.char_valid), 32'd0);
        tick(1);
        check("stall_e5", 32'(char_if.char_valid), 32'd0);
        tick(1);
        check("stall_valid", 32'(char_if.char_valid), 32'd1);
        check("stall_data", 32'(char_if.char_data), 32'h58);
        drain(100, "stall");
        check("stall_xfers", 32'(xfer_cnt - base), 32'd2);

        // Pointer wrap with an embedded carriage return.
        flush_to(ADDR_W'(2046));
        check("wrap_flush_ptr", 32'(read_index), 32'd2046);
        base = xfer_cnt;
        push_char(7'h48);
        push_char(7'h0D);
        push_char(7'h49);
        check("wrap_windex", 32'(write_index), 32'd1);
        drain(200, "wrap");
        check("wrap_ptr", 32'(read_index), 32'd1);
        check("wrap_pending", 32'(pending), 32'd0);
        check("wrap_xfers", 32'(xfer_cnt - base), 32'd2);

        // Flush on the same edge as ready: nothing is transferred.
        base = xfer_cnt;
        char_if.char_ready = 1'b0;
        push_char(7'h5A);
        wait_valid(50, "flush");
        check("flush_offer", 32'(char_if.char_data), 32'h5A);
        char_if.char_ready = 1'b1;
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        char_if.char_ready = 1'b0;
        check("flush_valid", 32'(char_if.char_valid), 32'd0);
        check("flush_ptr", 32'(read_index), 32'(write_index));
        check("flush_xfers", 32'(xfer_cnt - base), 32'd0);

        // Reset on the same edge as ready: character lost, outputs cleared.
        push_char(7'h51);
        wait_valid(50, "rstmid");
        char_if.char_ready = 1'b1;
        do_reset();
        check("rstmid_valid", 32'(char_if.char_valid), 32'd0);
        check("rstmid_data", 32'(char_if.char_data), 32'd0);
        check("rstmid_ptr", 32'(read_index), 32'd0);
        check("rstmid_empty", 32'(empty), 32'd1);
        check("rstmid_xfers", 32'(xfer_cnt - base), 32'd0);

        // Random writes, backpressure and occasional flushes.
        for (int it = 0; it < 2000; it++) begin
            r = $urandom_range(0, 99);
            char_if.char_ready = 1'($urandom_range(0, 1));
            if (r < 2) begin
                flush_to(write_index);
            end else if (r < 30) begin
                ch = DATA_W'($urandom_range(0, 127));
                push_char(ch);
            end else begin
                tick(1);
            end
        end
        drain(1000, "rand");
        check("rand_valid", 32'(char_if.char_valid), 32'd0);
        check("rand_ptr", 32'(read_index), 32'(write_index));
        check("rand_pending", 32'(pending), 32'd0);
        left = 0;
        foreach (exp_q[i]) if (exp_q[i] >= ASCII_SPACE) left++;
        check("rand_undelivered", 32'(left), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_buffer_reader
